// File: rtl/tl_mem_bridge.sv
// Single-outstanding TL-UL (single-beat) to simple memory-port bridge.
// Optional unsupported-request counter enabled by TL_MEM_BRIDGE_ERRCNT_EN.
module tl_mem_bridge (
    input  logic        clock,
    input  logic        reset,
    // TL-UL A channel
    output logic        auto_in_a_ready,
    input  logic        auto_in_a_valid,
    input  logic [2:0]  auto_in_a_bits_opcode,
    input  logic [2:0]  auto_in_a_bits_size,
    input  logic [2:0]  auto_in_a_bits_source,
    input  logic [35:0] auto_in_a_bits_address,
    input  logic [7:0]  auto_in_a_bits_mask,
    input  logic [63:0] auto_in_a_bits_data,
    // TL-UL D channel
    input  logic        auto_in_d_ready,
    output logic        auto_in_d_valid,
    output logic [2:0]  auto_in_d_bits_opcode,
    output logic [2:0]  auto_in_d_bits_size,
    output logic [2:0]  auto_in_d_bits_source,
    output logic [63:0] auto_in_d_bits_data,
    // memory request
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_write,
    output logic [35:0] mem_req_addr,
    output logic [7:0]  mem_req_mask,
    output logic [63:0] mem_req_wdata,
    // memory response
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_rdata
`ifdef TL_MEM_BRIDGE_ERRCNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_PUT_PART = 3'd1;
    localparam logic [2:0] OP_GET      = 3'd4;
    localparam logic [2:0] D_ACK       = 3'd0;
    localparam logic [2:0] D_ACK_DATA  = 3'd1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    typedef struct packed {
        logic [2:0]  size;
        logic [2:0]  source;
        logic [35:0] address;
        logic [7:0]  mask;
        logic [63:0] data;
    } aReq_t;

    state_t      state, nextState;
    aReq_t       hold;
    logic        isRead;
    logic [63:0] rdataReg;
    logic        aFire;
    logic        supported;

    assign aFire     = auto_in_a_valid && auto_in_a_ready;
    assign supported = ((auto_in_a_bits_opcode == OP_GET) ||
                        (auto_in_a_bits_opcode == OP_PUT_FULL) ||
                        (auto_in_a_bits_opcode == OP_PUT_PART)) &&
                       (auto_in_a_bits_size <= 3'd3);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            hold     <= '0;
            isRead   <= 1'b0;
            rdataReg <= '0;
        end else begin
            state <= nextState;
            if (aFire) begin
                hold.size    <= auto_in_a_bits_size;
                hold.source  <= auto_in_a_bits_source;
                hold.address <= auto_in_a_bits_address;
                hold.mask    <= auto_in_a_bits_mask;
                hold.data    <= auto_in_a_bits_data;
                // an unsupported Get is acked like a write: no data beat
                isRead       <= supported && (auto_in_a_bits_opcode == OP_GET);
            end
            if (state == WAIT && mem_resp_valid)
                rdataReg <= mem_resp_rdata;
        end
    end

    always_comb begin
        nextState             = state;
        auto_in_a_ready       = 1'b0;
        mem_req_valid         = 1'b0;
        mem_req_write         = 1'b0;
        auto_in_d_valid       = 1'b0;
        auto_in_d_bits_opcode = 3'd0;
        auto_in_d_bits_size   = 3'd0;
        auto_in_d_bits_source = 3'd0;
        auto_in_d_bits_data   = 64'd0;
        case (state)
            IDLE: begin
                auto_in_a_ready = 1'b1;
                if (auto_in_a_valid)
                    nextState = supported ? REQ : RESP;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                mem_req_write = !isRead;
                if (mem_req_ready)
                    nextState = isRead ? WAIT : RESP;
            end
            WAIT: begin
                if (mem_resp_valid)
                    nextState = RESP;
            end
            RESP: begin
                auto_in_d_valid       = 1'b1;
                auto_in_d_bits_opcode = isRead ? D_ACK_DATA : D_ACK;
                auto_in_d_bits_size   = hold.size;
                auto_in_d_bits_source = hold.source;
                auto_in_d_bits_data   = isRead ? rdataReg : 64'd0;
                if (auto_in_d_ready)
                    nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    assign mem_req_addr  = hold.address;
    assign mem_req_mask  = hold.mask;
    assign mem_req_wdata = hold.data;

`ifdef TL_MEM_BRIDGE_ERRCNT_EN
    logic [7:0] errCnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            errCnt <= 8'd0;
        else if (aFire && !supported && errCnt != 8'hFF)
            errCnt <= errCnt + 8'd1;
    end

    assign err_count = errCnt;
`endif

endmodule

// File: tb/tb_tl_mem_bridge.sv
// Directed self-checking bench for tl_mem_bridge; err_count checks only
// compile when TL_MEM_BRIDGE_ERRCNT_EN is defined.
module tb_tl_mem_bridge;

    logic        clock = 1'b0;
    logic        reset;
    logic        aReady, aValid;
    logic [2:0]  aOpcode, aSize, aSource;
    logic [35:0] aAddress;
    logic [7:0]  aMask;
    logic [63:0] aData;
    logic        dReady, dValid;
    logic [2:0]  dOpcode, dSize, dSource;
    logic [63:0] dData;
    logic        mReqValid, mReqReady, mReqWrite;
    logic [35:0] mReqAddr;
    logic [7:0]  mReqMask;
    logic [63:0] mReqWdata;
    logic        mRespValid;
    logic [63:0] mRespRdata;
`ifdef TL_MEM_BRIDGE_ERRCNT_EN
    logic [7:0]  errCount;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    tl_mem_bridge dut (
        .clock                  (clock),
        .reset                  (reset),
        .auto_in_a_ready        (aReady),
        .auto_in_a_valid        (aValid),
        .auto_in_a_bits_opcode  (aOpcode),
        .auto_in_a_bits_size    (aSize),
        .auto_in_a_bits_source  (aSource),
        .auto_in_a_bits_address (aAddress),
        .auto_in_a_bits_mask    (aMask),
        .auto_in_a_bits_data    (aData),
        .auto_in_d_ready        (dReady),
        .auto_in_d_valid        (dValid),
        .auto_in_d_bits_opcode  (dOpcode),
        .auto_in_d_bits_size    (dSize),
        .auto_in_d_bits_source  (dSource),
        .auto_in_d_bits_data    (dData),
        .mem_req_valid          (mReqValid),
        .mem_req_ready          (mReqReady),
        .mem_req_write          (mReqWrite),
        .mem_req_addr           (mReqAddr),
        .mem_req_mask           (mReqMask),
        .mem_req_wdata          (mReqWdata),
        .mem_resp_valid         (mRespValid),
        .mem_resp_rdata         (mRespRdata)
`ifdef TL_MEM_BRIDGE_ERRCNT_EN
        ,
        .err_count              (errCount)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic sendA(input logic [2:0] op, input logic [2:0] sz, input logic [2:0] src,
                         input logic [35:0] addr, input logic [7:0] mask, input logic [63:0] data);
        aValid = 1'b1; aOpcode = op; aSize = sz; aSource = src;
        aAddress = addr; aMask = mask; aData = data;
    endtask

    task automatic dropA();
        aValid = 1'b0; aOpcode = 3'd6; aSize = 3'd7; aSource = 3'd0;
        aAddress = '1; aMask = 8'h00; aData = '1;
    endtask

    initial begin
        reset = 1'b0; dropA(); dReady = 1'b0; mReqReady = 1'b0;
        mRespValid = 1'b0; mRespRdata = '0;
        #1;
        // reset values
        check("rst_a_ready", 64'(aReady), 64'd1);
        check("rst_d_valid", 64'(dValid), 64'd0);
        check("rst_mreq_valid", 64'(mReqValid), 64'd0);
        check("rst_mreq_write", 64'(mReqWrite), 64'd0);
        check("rst_mreq_addr", 64'(mReqAddr), 64'd0);
        check("rst_d_opcode", 64'(dOpcode), 64'd0);
        check("rst_d_data", dData, 64'd0);
`ifdef TL_MEM_BRIDGE_ERRCNT_EN
        check("rst_err_count", 64'(errCount), 64'd0);
`endif
        step(); step();
        reset = 1'b1;
        step();

        // Get, minimum read latency
        sendA(3'd4, 3'd3, 3'd5, 36'h0_8000_0000, 8'hFF, 64'd0);
        check("rd_c0_a_ready", 64'(aReady), 64'd1);
        step(); dropA();
        check("rd_c1_mreq_valid", 64'(mReqValid), 64'd1);
        check("rd_c1_mreq_write", 64'(mReqWrite), 64'd0);
        check("rd_c1_mreq_addr", 64'(mReqAddr), 64'h8000_0000);
        check("rd_c1_a_ready", 64'(aReady), 64'd0);
        mReqReady = 1'b1;
        step(); mReqReady = 1'b0;
        check("rd_c2_mreq_valid", 64'(mReqValid), 64'd0);
        check("rd_c2_d_valid", 64'(dValid), 64'd0);
        mRespValid = 1'b1; mRespRdata = 64'hDEAD_BEEF_CAFE_F00D;
        step(); mRespValid = 1'b0; mRespRdata = 64'h1234;
        check("rd_c3_d_valid", 64'(dValid), 64'd1);
        check("rd_c3_d_opcode", 64'(dOpcode), 64'd1);
        check("rd_c3_d_size", 64'(dSize), 64'd3);
        check("rd_c3_d_source", 64'(dSource), 64'd5);
        check("rd_c3_d_data", dData, 64'hDEAD_BEEF_CAFE_F00D);
        check("rd_c3_a_ready", 64'(aReady), 64'd0);
        dReady = 1'b1;
        step(); dReady = 1'b0;
        check("rd_c4_d_valid", 64'(dValid), 64'd0);
        check("rd_c4_a_ready", 64'(aReady), 64'd1);

        // PutPartial with stalled memory; stray response pulse must be ignored
        sendA(3'd1, 3'd2, 3'd2, 36'h1008, 8'h0F, 64'h1122_3344);
        step(); dropA();
        for (int i = 0; i < 4; i++) begin
            check("pp_mreq_valid", 64'(mReqValid), 64'd1);
            check("pp_mreq_write", 64'(mReqWrite), 64'd1);
            check("pp_mreq_addr", 64'(mReqAddr), 64'h1008);
            check("pp_mreq_mask", 64'(mReqMask), 64'h0F);
            check("pp_mreq_wdata", mReqWdata, 64'h1122_3344);
            check("pp_d_valid", 64'(dValid), 64'd0);
            mRespValid = (i == 1);
            mReqReady  = (i == 3);
            step();
        end
        mReqReady = 1'b0; mRespValid = 1'b0;
        // D backpressure for 5 cycles while a new A waits
        aValid = 1'b1; aOpcode = 3'd4; aSize = 3'd3;
        for (int i = 0; i < 5; i++) begin
            check("pp_bp_d_valid", 64'(dValid), 64'd1);
            check("pp_bp_d_opcode", 64'(dOpcode), 64'd0);
            check("pp_bp_d_size", 64'(dSize), 64'd2);
            check("pp_bp_d_source", 64'(dSource), 64'd2);
            check("pp_bp_d_data", dData, 64'd0);
            check("pp_bp_a_ready", 64'(aReady), 64'd0);
            check("pp_bp_mreq_valid", 64'(mReqValid), 64'd0);
            step();
        end
        dReady = 1'b1;
        step(); dReady = 1'b0; dropA();
        check("pp_idle_a_ready", 64'(aReady), 64'd1);
        check("pp_idle_d_valid", 64'(dValid), 64'd0);

        // unsupported Arithmetic opcode: immediate AccessAck, no memory access
        sendA(3'd2, 3'd2, 3'd7, 36'h2000, 8'hFF, 64'h55);
        step(); dropA();
        check("un_mreq_valid", 64'(mReqValid), 64'd0);
        check("un_d_valid", 64'(dValid), 64'd1);
        check("un_d_opcode", 64'(dOpcode), 64'd0);
        check("un_d_source", 64'(dSource), 64'd7);
        check("un_d_data", dData, 64'd0);
`ifdef TL_MEM_BRIDGE_ERRCNT_EN
        check("un_err_count_1", 64'(errCount), 64'd1);
`endif
        dReady = 1'b1;
        step(); dReady = 1'b0;
        for (int i = 0; i < 255; i++) begin
            sendA(3'd2, 3'd2, 3'd7, 36'h2000, 8'hFF, 64'h55);
            step(); dropA(); dReady = 1'b1;
            step(); dReady = 1'b0;
        end
`ifdef TL_MEM_BRIDGE_ERRCNT_EN
        check("un_err_count_sat", 64'(errCount), 64'd255);
`endif
        // Get with size 4 is unsupported: no memory request
        sendA(3'd4, 3'd4, 3'd3, 36'h3000, 8'hFF, 64'd0);
        step(); dropA();
        check("big_mreq_valid", 64'(mReqValid), 64'd0);
        check("big_d_valid", 64'(dValid), 64'd1);
        check("big_d_source", 64'(dSource), 64'd3);
`ifdef TL_MEM_BRIDGE_ERRCNT_EN
        check("big_err_count_hold", 64'(errCount), 64'd255);
`endif
        dReady = 1'b1;
        step(); dReady = 1'b0;

        // reset while waiting on a read
        sendA(3'd4, 3'd3, 3'd1, 36'h4000, 8'hFF, 64'd0);
        step(); dropA(); mReqReady = 1'b1;
        step(); mReqReady = 1'b0;
        check("rw_wait_mreq_valid", 64'(mReqValid), 64'd0);
        check("rw_wait_a_ready", 64'(aReady), 64'd0);
        reset = 1'b0;
        #1;
        check("rw_rst_a_ready", 64'(aReady), 64'd1);
        check("rw_rst_d_valid", 64'(dValid), 64'd0);
        step(); reset = 1'b1;
        mRespValid = 1'b1; mRespRdata = 64'hBAD;
        step(); mRespValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rw_late_d_valid", 64'(dValid), 64'd0);
            check("rw_late_a_ready", 64'(aReady), 64'd1);
            step();
        end

        // PutFull with immediate ready: minimum write latency
        sendA(3'd0, 3'd3, 3'd4, 36'h40, 8'hFF, 64'hA5A5_0000_0000_5A5A);
        step(); dropA();
        check("wr_c1_mreq_valid", 64'(mReqValid), 64'd1);
        check("wr_c1_mreq_write", 64'(mReqWrite), 64'd1);
        check("wr_c1_mreq_wdata", mReqWdata, 64'hA5A5_0000_0000_5A5A);
        mReqReady = 1'b1;
        step(); mReqReady = 1'b0;
        check("wr_c2_d_valid", 64'(dValid), 64'd1);
        check("wr_c2_d_opcode", 64'(dOpcode), 64'd0);
        check("wr_c2_d_source", 64'(dSource), 64'd4);
        dReady = 1'b1;
        step(); dReady = 1'b0;
        check("wr_c3_a_ready", 64'(aReady), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tl_mem_bridge.md
TL_MEM_BRIDGE -- requirements
Module: tl_mem_bridge

Interface
REQ-001 SHALL have port clock, input, 1, single clock; all state on its rising edge.
REQ-002 SHALL have port reset, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have TL-UL slave A channel: auto_in_a_ready out 1; auto_in_a_valid in 1; auto_in_a_bits_opcode in 3; auto_in_a_bits_size in 3; auto_in_a_bits_source in 3; auto_in_a_bits_address in 36; auto_in_a_bits_mask in 8; auto_in_a_bits_data in 64.
REQ-004 SHALL have TL-UL slave D channel: auto_in_d_ready in 1; auto_in_d_valid out 1; auto_in_d_bits_opcode out 3; auto_in_d_bits_size out 3; auto_in_d_bits_source out 3; auto_in_d_bits_data out 64.
REQ-005 SHALL have memory request port: mem_req_valid out 1; mem_req_ready in 1; mem_req_write out 1; mem_req_addr out 36; mem_req_mask out 8; mem_req_wdata out 64.
REQ-006 SHALL have memory response port: mem_resp_valid in 1; mem_resp_rdata in 64 (read data, one pulse per read).

Function
REQ-007 SHALL sit directly downstream of the TL buffer out port and convert single-beat TL-UL accesses into memory-port transactions, one outstanding request at a time.
REQ-008 SHALL implement FSM IDLE, REQ, WAIT, RESP; reset state IDLE.
REQ-009 SHALL drive auto_in_a_ready=1 only in IDLE; A fires when auto_in_a_valid && auto_in_a_ready.
REQ-010 On A fire SHALL latch opcode, size, source, address, mask, data into holding registers.
REQ-011 Supported request: opcode Get(4), PutFullData(0), PutPartialData(1) with size<=3; anything else unsupported.
REQ-012 IDLE->REQ on supported A fire; IDLE->RESP on unsupported A fire with no memory access.
REQ-013 In REQ SHALL assert mem_req_valid=1 with mem_req_write=(opcode!=Get), addr/mask/wdata from holding registers, held stable until mem_req_ready.
REQ-014 REQ with mem_req_ready: write->RESP, read->WAIT; without ready stay REQ.
REQ-015 WAIT: on mem_resp_valid SHALL capture mem_resp_rdata and go RESP; same-cycle response as request acceptance is not legal and need not be handled.
REQ-016 mem_resp_valid outside WAIT SHALL be ignored.
REQ-017 RESP: auto_in_d_valid=1; opcode AccessAckData(1) for Get, else AccessAck(0); size and source echo latched values; data = captured rdata for Get, 0 otherwise; all D fields stable until D fires.
REQ-018 RESP with auto_in_d_ready -> IDLE; next A accepted no earlier than the following cycle (no same-cycle D fire/A accept).
REQ-019 Minimum read latency: A fire cycle 0, mem_req_valid cycle 1, mem response cycle 2, auto_in_d_valid cycle 3.
REQ-020 Minimum write latency: A fire cycle 0, mem_req_valid cycle 1 with ready, auto_in_d_valid cycle 2.

Reset
REQ-021 Reset assertion SHALL force IDLE immediately regardless of state, including mid-transaction; in-flight request is dropped, no D response issued.
REQ-022 Reset values: auto_in_a_ready=1 after deassertion (IDLE); auto_in_d_valid=0; mem_req_valid=0; mem_req_write=0; all holding/data registers 0; D bits outputs 0.

Configuration
REQ-023 With TL_MEM_BRIDGE_ERRCNT_EN defined SHALL add output err_count (8 bits, reset 0) incremented once per unsupported A fire, saturating at 255.
REQ-024 Without TL_MEM_BRIDGE_ERRCNT_EN SHALL have no err_count port and no counter logic; all other behaviour identical.

Verification
REQ-025 Get addr 0x80000000 size 3 source 5; mem_req_ready=1; rdata 0xDEADBEEF_CAFEF00D next cycle -> D valid cycle 3, opcode 1, size 3, source 5, data 0xDEADBEEFCAFEF00D.
REQ-026 PutPartial addr 0x1008 mask 0x0F data 0x11223344 source 2; mem_req_ready held 0 for 3 cycles -> mem_req fields stable 4 cycles, then D opcode 0, source 2, data 0.
REQ-027 Opcode 2 (Arithmetic) source 7 -> no mem_req_valid, D opcode 0 source 7 on cycle 1; with macro err_count=1; 256 such requests -> err_count=255.
REQ-028 auto_in_d_ready=0 for 5 cycles in RESP -> D fields stable, auto_in_a_ready=0 throughout; ready=1 -> IDLE next cycle.
REQ-029 Reset asserted while in WAIT -> IDLE, d_valid=0; late mem_resp_valid after reset -> ignored, no D response.
